stage_1_fetch: RTL and testbench

Instruction fetch stage: the producer end of the `instruction`/`pc` interface consumed by the decode stage. It holds the fetch PC, issues in-order requests to instruction memory over a valid/ready handshake, and buffers responses in a small FIFO. It presents one instruction per cycle to decode, honours decode backpressure (`stall`), and flushes on a jump redirect, discarding responses already in flight.

---
 rtl/stage_1_fetch.sv | 139 +++++++++++++
 tb/tb_stage_1_fetch.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_1_fetch.sv
// Instruction fetch stage: issues in-order imem requests, buffers responses, and feeds decode.
// Optional FETCH_MISALIGN_CHECK_EN halts fetch on a misaligned redirect target.
package stage_1_fetch_pkg;
    typedef enum logic [1:0] {
        DEBUG_OK               = 2'd0,
        DEBUG_MISALIGNED_FETCH = 2'd1
    } DebugStatus;
endpackage

module stage_1_fetch
    import stage_1_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        stall,
    input  logic        jump_enable,
    input  logic [31:0] jump_address,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    output DebugStatus  debug_out
);
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   target;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic [31:0]   fifo_pc    [FIFO_DEPTH];
    logic          resp_accept;
    logic          push;
    logic          pop;
    logic          handshake;
    logic          halt;
    logic [CW:0]   occupancy;

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            halt <= 1'b0;
        end else if (jump_enable && (jump_address[1:0] != 2'b00)) begin
            halt <= 1'b1;
        end
    end

    assign debug_out = halt ? DEBUG_MISALIGNED_FETCH : DEBUG_OK;
`else
    assign halt      = 1'b0;
    assign debug_out = DEBUG_OK;
`endif

    always_comb begin
        target      = jump_address & 32'hFFFF_FFFC;
        resp_accept = imem_resp_valid && (outstanding != '0);
        push        = resp_accept && (discard == '0) && !jump_enable;
        pop         = !stall && (count != '0) && !jump_enable;
        // Slots already promised to in-flight requests count against the buffer.
        occupancy   = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
        imem_req_valid = !reset && !jump_enable && !halt
                         && (occupancy < (CW+1)'(FIFO_DEPTH));
        handshake     = imem_req_valid && imem_req_ready;
        imem_req_addr = fetch_pc;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_resp_data;
            fifo_pc[wr_ptr]    <= resp_pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc        <= {RESET_PC[31:2], 2'b00};
            resp_pc         <= {RESET_PC[31:2], 2'b00};
            outstanding     <= '0;
            discard         <= '0;
            count           <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            valid_out       <= 1'b0;
            instruction_out <= NOP;
            pc_out          <= '0;
        end else begin
            outstanding <= outstanding + CW'(handshake) - CW'(resp_accept);
            if (jump_enable) begin
                // Everything still in flight belongs to the old stream.
                fetch_pc        <= target;
                resp_pc         <= target;
                count           <= '0;
                wr_ptr          <= '0;
                rd_ptr          <= '0;
                discard         <= outstanding - CW'(resp_accept);
                valid_out       <= 1'b0;
                instruction_out <= NOP;
            end else begin
                if (handshake) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (resp_accept && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
                if (push) begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
                if (!stall) begin
                    if (count != '0) begin
                        instruction_out <= fifo_instr[rd_ptr];
                        pc_out          <= fifo_pc[rd_ptr];
                        valid_out       <= 1'b1;
                    end else begin
                        instruction_out <= NOP;
                        valid_out       <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_stage_1_fetch.sv
// Directed bench for stage_1_fetch; memory returns ~addr as the instruction word.
module tb_stage_1_fetch;
    import stage_1_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        stall = 1'b0;
    logic        jump_enable = 1'b0;
    logic [31:0] jump_address = '0;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        valid_out;
    DebugStatus  debug_out;

    int checks = 0;
    int errors = 0;
    int unsigned mem_lat = 1;
    int unsigned cyc = 0;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } req_t;
    req_t q[$];

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    stage_1_fetch #(
        .RESET_PC  (32'h0000_0100),
        .FIFO_DEPTH(2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .stall          (stall),
        .jump_enable    (jump_enable),
        .jump_address   (jump_address),
        .instruction_out(instruction_out),
        .pc_out         (pc_out),
        .valid_out      (valid_out),
        .debug_out      (debug_out)
    );

    // In-order memory with fixed latency, reset together with the DUT.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            #1;
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
            end
            cyc++;
            #1;
            if (q.size() > 0 && q[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = ~q[0].addr;
                void'(q.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
            end
        end
    end

    // Leaves the bench 1 time unit into cycle 0 (first cycle with reset low).
    task automatic apply_reset(input int unsigned lat);
        @(negedge clk);
        reset = 1'b1;
        stall = 1'b0;
        jump_enable = 1'b0;
        jump_address = '0;
        imem_req_ready = 1'b1;
        mem_lat = lat;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic wait_valid(input int max, output bit found);
        found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            @(negedge clk);
            #1;
            if (valid_out === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_out); end
        checks++; if (instruction_out !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", instruction_out, NOP); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 00000000", pc_out); end
        checks++; if (debug_out !== DEBUG_OK) begin errors++; $display("FAIL reset_debug got %0d exp %0d", debug_out, DEBUG_OK); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); end
    endtask

    task automatic test_startup();
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'h100; exp_addr[1] = 32'h104; exp_addr[2] = 32'h108;
        apply_reset(1);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_addr[c]) begin
                errors++;
                $display("FAIL startup_req%0d got valid=%b addr=%h exp 1 %h", c, imem_req_valid, imem_req_addr, exp_addr[c]);
            end
            checks++;
            if (valid_out !== 1'b0) begin errors++; $display("FAIL startup_early_valid%0d got %b exp 0", c, valid_out); end
        end
        for (int c = 3; c < 6; c++) begin
            logic [31:0] epc;
            epc = 32'h104 + 32'(4 * (c - 3));
            @(negedge clk); #1;
            checks++;
            if (valid_out !== 1'b1 || pc_out !== epc || instruction_out !== ~(epc - 32'd4)) begin
                errors++;
                $display("FAIL startup_out%0d got v=%b pc=%h ins=%h exp 1 %h %h", c, valid_out, pc_out, instruction_out, epc, ~(epc - 32'd4));
            end
        end
    endtask

    // Continues the stream left by test_startup (now in cycle 5).
    task automatic test_backpressure();
        bit found;
        logic [31:0] epc;
        @(negedge clk);
        stall = 1'b1;
        #1;
        for (int c = 6; c <= 10; c++) begin
            if (c > 6) begin @(negedge clk); #1; end
            checks++;
            if (valid_out !== 1'b1 || pc_out !== 32'h110 || instruction_out !== ~32'h10C) begin
                errors++;
                $display("FAIL stall_hold%0d got v=%b pc=%h ins=%h exp 1 00000110 %h", c, valid_out, pc_out, instruction_out, ~32'h10C);
            end
            checks++;
            if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_no_req%0d got %b exp 0", c, imem_req_valid); end
        end
        @(negedge clk);
        stall = 1'b0;
        #1;
        epc = 32'h114;
        for (int n = 0; n < 4; n++) begin
            wait_valid(10, found);
            checks++;
            if (!found || pc_out !== epc || instruction_out !== ~(epc - 32'd4)) begin
                errors++;
                $display("FAIL release_seq%0d got found=%b pc=%h ins=%h exp %h %h", n, found, pc_out, instruction_out, epc, ~(epc - 32'd4));
            end
            epc += 32'd4;
        end
    endtask

    task automatic test_redirect_inflight();
        bit found;
        apply_reset(3);
        @(negedge clk); #1;
        @(negedge clk);
        jump_enable = 1'b1;
        jump_address = 32'h400;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_req_during got %b exp 0", imem_req_valid); end
        @(negedge clk);
        jump_enable = 1'b0;
        #1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL redir_valid_low got %b exp 0", valid_out); end
        wait_valid(20, found);
        checks++;
        if (!found || pc_out !== 32'h404 || instruction_out !== ~32'h400) begin
            errors++;
            $display("FAIL redir_first got found=%b pc=%h ins=%h exp 00000404 %h", found, pc_out, instruction_out, ~32'h400);
        end
        wait_valid(20, found);
        checks++;
        if (!found || pc_out !== 32'h408) begin errors++; $display("FAIL redir_second got found=%b pc=%h exp 00000408", found, pc_out); end
    endtask

    task automatic test_redirect_stall_resp();
        bit found;
        apply_reset(1);
        repeat (4) @(negedge clk);
        stall = 1'b1;
        jump_enable = 1'b1;
        jump_address = 32'h600;
        #1;
        checks++; if (imem_resp_valid !== 1'b1) begin errors++; $display("FAIL combo_resp_present got %b exp 1", imem_resp_valid); end
        @(negedge clk);
        stall = 1'b0;
        jump_enable = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || instruction_out !== NOP) begin
            errors++;
            $display("FAIL combo_flush got v=%b ins=%h exp 0 %h", valid_out, instruction_out, NOP);
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h600) begin
            errors++;
            $display("FAIL combo_target_req got v=%b addr=%h exp 1 00000600", imem_req_valid, imem_req_addr);
        end
        wait_valid(10, found);
        checks++;
        if (!found || pc_out !== 32'h604 || instruction_out !== ~32'h600) begin
            errors++;
            $display("FAIL combo_first got found=%b pc=%h ins=%h exp 00000604 %h", found, pc_out, instruction_out, ~32'h600);
        end
    endtask

    task automatic test_wrap();
        bit found;
        apply_reset(1);
        jump_enable = 1'b1;
        jump_address = 32'hFFFF_FFFC;
        @(negedge clk);
        jump_enable = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_req0 got v=%b addr=%h exp 1 fffffffc", imem_req_valid, imem_req_addr);
        end
        @(negedge clk); #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_req1 got v=%b addr=%h exp 1 00000000", imem_req_valid, imem_req_addr);
        end
        wait_valid(10, found);
        checks++;
        if (!found || pc_out !== 32'h0 || instruction_out !== 32'h0000_0003) begin
            errors++;
            $display("FAIL wrap_first got found=%b pc=%h ins=%h exp 00000000 00000003", found, pc_out, instruction_out);
        end
        wait_valid(10, found);
        checks++;
        if (!found || pc_out !== 32'h4) begin errors++; $display("FAIL wrap_second got found=%b pc=%h exp 00000004", found, pc_out); end
    endtask

    task automatic test_misalign();
        bit found;
        apply_reset(1);
        jump_enable = 1'b1;
        jump_address = 32'h202;
        @(negedge clk);
        jump_enable = 1'b0;
        #1;
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            checks++;
            if (imem_req_valid !== 1'b0 || debug_out === DEBUG_OK || valid_out !== 1'b0) begin
                errors++;
                $display("FAIL misalign_halt%0d got req=%b dbg=%0d v=%b exp 0 not-OK 0", c, imem_req_valid, debug_out, valid_out);
            end
        end
`else
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200 || debug_out !== DEBUG_OK) begin
            errors++;
            $display("FAIL misalign_clear got req=%b addr=%h dbg=%0d exp 1 00000200 0", imem_req_valid, imem_req_addr, debug_out);
        end
        wait_valid(10, found);
        checks++;
        if (!found || pc_out !== 32'h204 || instruction_out !== ~32'h200) begin
            errors++;
            $display("FAIL misalign_first got found=%b pc=%h ins=%h exp 00000204 %h", found, pc_out, instruction_out, ~32'h200);
        end
`endif
        apply_reset(1);
        checks++;
        if (debug_out !== DEBUG_OK || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            errors++;
            $display("FAIL misalign_reset got dbg=%0d req=%b addr=%h exp 0 1 00000100", debug_out, imem_req_valid, imem_req_addr);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_stall_resp();
        test_wrap();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
